dq_format_decoder_pipe: RTL
===========================

# dq_format_decoder_pipe

Second-generation DQ-form decoder for the Power ISA 3.0B front end. It decodes `lq`, `lxv` and `stxv`, sign-extends and scales the DQ displacement, and classifies register-file usage. Decoded micro-ops are buffered in a parametrised output FIFO with valid/ready handshakes on both sides. The block sits beside the other format decoders, is fed by fetch/predecode, and drains into the issue stage.

## Interface
- `opcodeWidth`, 6, primary opcode field width
- `regWidth`, 6, register index width; covers GPR 0–31 and VSR 0–63
- `immWidth`, 64, width of the sign-extended, scaled immediate output
- `instructionWidth`, 32, instruction word width
- `tagWidth`, 8, opaque instruction tag width (passed through)
- `fifoDepth`, 4, output FIFO entries; power of two, ≥2
- `regImm`=0, `regRead`=1, `regWrite`=2, `regReadWrite`=3: register-use encodings

Ports:
- `clock_i`  in  1  clock
- `reset_i`  in  1  synchronous, active-high reset
- `flush_i`  in  1  discard all buffered entries
- `valid_i`  in  1  instruction present
- `instruction_i`  in  32  instruction word, bit 0 = MSB (ISA numbering)
- `tag_i`  in  tagWidth  instruction tag
- `ready_o`  out  1  block can accept this cycle
- `stall_o`  out  1  equals `~ready_o`
- `valid_o`  out  1  FIFO head valid
- `ready_i`  in  1  downstream accepts head
- `op_o`  out  2  0 = lq, 1 = lxv, 2 = stxv
- `reg1_o`, `reg2_o`  out  regWidth  target/source (RT, or TX‖T / SX‖S), base RA
- `reg1File_o`  out  1  0 = GPR, 1 = VSR
- `reg1Use_o`, `reg2Use_o`  out  2  register-use encoding
- `imm_o`  out  immWidth  sign-extended DQ‖0b0000
- `illegal_o`  out  1  invalid instruction form
- `tag_o`  out  tagWidth  tag of the head entry
- `decodeCount_o`  out  32  saturating count of decoded entries

## Operation
- Accept occurs when `valid_i & ready_o`. Decode is combinational on the accepted word. The result is pushed at the clock edge, unless the word is not DQ-form.
- Opcode 56 decodes as `lq`:
  - reg1 = RT (GPR), use `regWrite`.
  - `illegal_o`=1 if RT is odd, if RT==RA, or if bits 28:31≠0.
- Opcode 61 decodes by XO in bits 29:31:
  - XO=1: `lxv`, reg1 = {bit28, bits 6:10} (VSR), use `regWrite`.
  - XO=5: `stxv`, reg1 = {bit28, bits 6:10} (VSR), use `regRead`.
  - Any other XO belongs to the DS-form decoder. The word is consumed and dropped with no push.
- Any other opcode is consumed and dropped with no push.
- reg2 = RA, zero-extended. `reg2Use_o` = `regRead`, or `regImm` when RA==0.
- `imm_o` = sign-extend(bits 16:27) shifted left by 4, at `immWidth`.
- Illegal entries are still pushed, with all fields populated, so issue can raise the exception in order.
- Pop occurs when `valid_o & ready_i`.
- `ready_o` = FIFO not full. It does not look at `ready_i`, so there is no combinational path from `ready_i` to `ready_o`.
- `flush_i`:
  - Clears the pointers and count.
  - An accept in the same cycle is dropped.
  - `ready_o`=1 on the next cycle.
  - `decodeCount_o` is not changed by a flush.
- `decodeCount_o` increments on each push and saturates at 2^32−1.

## Timing
- Latency is 1 cycle: a word accepted at edge N appears at the head with `valid_o`=1 after edge N, provided the FIFO was empty.
- Throughput is one per cycle. Simultaneous push and pop keeps the count unchanged.
- Full: `ready_o`=0. A pop in that cycle frees a slot; `ready_o` rises on the following cycle.
- Empty: `valid_o`=0. Head outputs hold their last value; they are don't-care for checking.
- Pointer wrap is modulo `fifoDepth`. Count width is log2(fifoDepth)+1.
- `valid_o` deasserts only after a pop. Head fields are stable while `valid_o & ~ready_i`.
- Reset values:
  - `valid_o`=0, `ready_o`=1, `stall_o`=0, `decodeCount_o`=0.
  - `op_o`, `reg*`, `imm_o`, `tag_o`, `illegal_o`, `reg1File_o` = 0.
  - Use fields = `regImm`.
- Reset applied mid-operation discards all entries. Reset has priority over flush, and flush has priority over push and pop.

## Structure
- Shared package `power_isa_pkg`:
  - opcode constants (56, 61)
  - XO constants (1, 5)
  - reg-use encodings
  - `dq_op_t` enum
  - packed decoded-entry struct
- Sub-module `decode_fifo` (parametrised width and depth, sync reset, flush). It is reusable by the other format decoders.

## Test plan
- `lq` 0xE0830010, tag 0x11, `ready_i`=1 → next cycle `valid_o`=1, op=0, reg1=4 (GPR, write), reg2=3 (read), `imm_o`=0x10, illegal=0, tag 0x11.
- `lxv` 0xF421FFF9 → reg1=33 (VSR, write), reg2=1, `imm_o`=0xFFFF_FFFF_FFFF_FFF0. `stxv` 0xF421FFF5 → op=2, reg1=1 (VSR, read), same imm.
- `lq` 0xE0A30010 (RT=5) → pushed with illegal=1. Word 0x7C000000 (opcode 31) and opcode 61 with XO=2 → no push, `decodeCount_o` unchanged.
- Hold `ready_i`=0 and push 4 valid words → `ready_o`=0 after the 4th, and `valid_i` is ignored. Then `ready_i`=1 → pops in order with matching tags, and `ready_o` rises one cycle after the first pop.
- Fill 3 entries, then assert `flush_i` with `valid_i`=1 → next cycle `valid_o`=0, count=0, and the flushed-cycle word is absent.
- Push 2 entries, assert `reset_i` for one cycle → all outputs at their reset values and `decodeCount_o`=0. The next word appears after 1 cycle.

Source files
------------

// File: rtl/power_isa_pkg.sv
// Shared Power ISA decode definitions: field widths, opcode/XO constants,
// register-use encodings and the decoded DQ-form entry layout.
package power_isa_pkg;

    localparam int opcodeWidth      = 6;
    localparam int regWidth         = 6;
    localparam int immWidth         = 64;
    localparam int instructionWidth = 32;
    localparam int tagWidth         = 8;

    localparam logic [opcodeWidth-1:0] OPC_LQ   = 6'd56;
    localparam logic [opcodeWidth-1:0] OPC_DQ61 = 6'd61;

    localparam logic [2:0] XO_LXV  = 3'd1;
    localparam logic [2:0] XO_STXV = 3'd5;

    typedef enum logic [1:0] {
        regImm       = 2'd0,
        regRead      = 2'd1,
        regWrite     = 2'd2,
        regReadWrite = 2'd3
    } reg_use_t;

    typedef enum logic [1:0] {
        DQ_LQ   = 2'd0,
        DQ_LXV  = 2'd1,
        DQ_STXV = 2'd2
    } dq_op_t;

    typedef struct packed {
        dq_op_t                op;
        logic [regWidth-1:0]   reg1;
        logic                  reg1_file;
        reg_use_t              reg1_use;
        logic [regWidth-1:0]   reg2;
        reg_use_t              reg2_use;
        logic [immWidth-1:0]   imm;
        logic                  illegal;
        logic [tagWidth-1:0]   tag;
    } dq_entry_t;

endpackage

// File: rtl/dq_format_decoder_pipe_if.sv
// Fetch-side and issue-side handshake bundle of the DQ-form decoder.
// slave is the decoder's view, master is the driver/consumer view.
interface dq_format_decoder_pipe_if;

    logic                                          valid_i;
    logic [power_isa_pkg::instructionWidth-1:0]    instruction_i;
    logic [power_isa_pkg::tagWidth-1:0]            tag_i;
    logic                                          ready_o;
    logic                                          stall_o;

    logic                                          valid_o;
    logic                                          ready_i;
    logic [1:0]                                    op_o;
    logic [power_isa_pkg::regWidth-1:0]            reg1_o;
    logic [power_isa_pkg::regWidth-1:0]            reg2_o;
    logic                                          reg1File_o;
    logic [1:0]                                    reg1Use_o;
    logic [1:0]                                    reg2Use_o;
    logic [power_isa_pkg::immWidth-1:0]            imm_o;
    logic                                          illegal_o;
    logic [power_isa_pkg::tagWidth-1:0]            tag_o;
    logic [31:0]                                   decodeCount_o;

    modport slave (
        input  valid_i, instruction_i, tag_i, ready_i,
        output ready_o, stall_o, valid_o, op_o, reg1_o, reg2_o, reg1File_o,
               reg1Use_o, reg2Use_o, imm_o, illegal_o, tag_o, decodeCount_o
    );

    modport master (
        output valid_i, instruction_i, tag_i, ready_i,
        input  ready_o, stall_o, valid_o, op_o, reg1_o, reg2_o, reg1File_o,
               reg1Use_o, reg2Use_o, imm_o, illegal_o, tag_o, decodeCount_o
    );

endinterface

// File: rtl/decode_fifo.sv
// Generic decoded-entry FIFO with flush, shared by the format decoders.
// The head is a registered read of the array, bypassed when a push lands in an empty queue.
module decode_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE    = 1;
    localparam logic [AW-1:0] PTR_ONE    = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == FULL_COUNT);
    assign valid_o = (count_q != '0);
    assign data_o  = head_q;

    // Flush outranks both push and pop.
    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & valid_o & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
            else if (!do_push && do_pop) count_d = count_q - CNT_ONE;
            // The incoming word becomes head only when nothing else remains ahead of it.
            if (do_push && ((count_q == '0) || ((count_q == CNT_ONE) && do_pop)))
                head_d = data_i;
            else if (count_d != '0)
                head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clock_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/dq_format_decoder_pipe.sv
// DQ-form decoder (lq, lxv, stxv): combinational field decode into a
// buffered micro-op FIFO, plus a saturating count of decoded entries.
module dq_format_decoder_pipe
    import power_isa_pkg::*;
#(
    parameter int fifoDepth = 4
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     flush_i,
    dq_format_decoder_pipe_if.slave  bus
);

    logic [instructionWidth-1:0] instr;
    logic [opcodeWidth-1:0]      opcode;
    logic [4:0]                  rt, ra;
    logic [11:0]                 dq;
    logic [2:0]                  xo;
    logic                        tx;

    // ISA bit i lives at instr[31-i].
    assign instr  = bus.instruction_i;
    assign opcode = instr[31:26];
    assign rt     = instr[25:21];
    assign ra     = instr[20:16];
    assign dq     = instr[15:4];
    assign tx     = instr[3];
    assign xo     = instr[2:0];

    dq_entry_t entry;
    logic      is_dq;

    always_comb begin
        entry          = '0;
        is_dq          = 1'b0;
        entry.reg2     = {1'b0, ra};
        entry.reg2_use = (ra == 5'd0) ? regImm : regRead;
        entry.imm      = {{(immWidth-16){dq[11]}}, dq, 4'b0000};
        entry.tag      = bus.tag_i;
        case (opcode)
            OPC_LQ: begin
                is_dq           = 1'b1;
                entry.op        = DQ_LQ;
                entry.reg1      = {1'b0, rt};
                entry.reg1_file = 1'b0;
                entry.reg1_use  = regWrite;
                // lq targets an even/odd GPR pair that must not overlap the base.
                entry.illegal   = rt[0] | (rt == ra) | (instr[3:0] != 4'd0);
            end
            OPC_DQ61: begin
                entry.reg1      = {tx, rt};
                entry.reg1_file = 1'b1;
                if (xo == XO_LXV) begin
                    is_dq          = 1'b1;
                    entry.op       = DQ_LXV;
                    entry.reg1_use = regWrite;
                end else if (xo == XO_STXV) begin
                    is_dq          = 1'b1;
                    entry.op       = DQ_STXV;
                    entry.reg1_use = regRead;
                end
            end
            default: is_dq = 1'b0;
        endcase
    end

    logic      fifo_full, head_valid, push;
    dq_entry_t head;

    assign push = bus.valid_i & ~fifo_full & is_dq & ~flush_i;

    decode_fifo #(
        .WIDTH ($bits(dq_entry_t)),
        .DEPTH (fifoDepth)
    ) u_fifo (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .flush_i (flush_i),
        .push_i  (push),
        .data_i  (entry),
        .full_o  (fifo_full),
        .pop_i   (bus.ready_i),
        .valid_o (head_valid),
        .data_o  (head)
    );

    logic [31:0] decode_count_q, decode_count_d;

    always_comb begin
        decode_count_d = decode_count_q;
        if (push && (decode_count_q != 32'hFFFF_FFFF))
            decode_count_d = decode_count_q + 32'd1;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) decode_count_q <= '0;
        else         decode_count_q <= decode_count_d;
    end

    assign bus.ready_o       = ~fifo_full;
    assign bus.stall_o       = fifo_full;
    assign bus.valid_o       = head_valid;
    assign bus.op_o          = head.op;
    assign bus.reg1_o        = head.reg1;
    assign bus.reg1File_o    = head.reg1_file;
    assign bus.reg1Use_o     = head.reg1_use;
    assign bus.reg2_o        = head.reg2;
    assign bus.reg2Use_o     = head.reg2_use;
    assign bus.imm_o         = head.imm;
    assign bus.illegal_o     = head.illegal;
    assign bus.tag_o         = head.tag;
    assign bus.decodeCount_o = decode_count_q;

endmodule
